lms_coef_update: RTL and testbench
==================================

# lms_coef_update

Sign-free LMS coefficient adaptation engine for the 16-tap equalizer FIR. It sits directly upstream of the filter's coefficient port. It keeps its own 16-deep history of the equalizer input samples. On each error event it forms e = dn − yn and updates all 16 coefficients serially, one tap per clock. The coefficient bank it owns drives the filter's `coef[15:0]` input continuously.

## Interface
- `MU_SHIFT`, default 4: step size μ = 2^−MU_SHIFT; legal range 0..15.
- `INIT_TAP`, default 0: index of the tap reset to 0x7FFF (unity). All other taps reset to 0.
- `clk` input 1: clock; all logic is rising-edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `x_valid` input 1: new equalizer input sample present on `xn`.
- `xn` input 16 signed: equalizer input sample, Q1.15.
- `err_valid` input 1: `yn` and `dn` are valid and aligned with the current history.
- `yn` input 16 signed: filter output, Q1.15.
- `dn` input 16 signed: desired/training symbol, Q1.15.
- `adapt_en` input 1: when 0, `err_valid` is ignored and coefficients are frozen.
- `ready` output 1: high only in IDLE; events are accepted only while it is high.
- `upd_done` output 1: one-cycle pulse when all 16 taps have been updated.
- `coef[15:0]` output 16×16 signed: coefficient bank, Q1.15, registered.

## Operation
- History register `x_hist[0..15]`, with `x_hist[0]` the newest sample. It resets to all 0.
- A sample is accepted when `x_valid && ready`: `x_hist[0]` ← xn and `x_hist[k]` ← `x_hist[k−1]`. When `ready` = 0, `x_valid` is dropped (no buffering).
- An error event is accepted when `err_valid && adapt_en && ready`. On acceptance:
  - e = sat16(dn − yn). The difference is computed in 17 bits and clamped to [−32768, 32767].
  - e is latched into an internal register.
- FSM states: IDLE, UPDATE, DONE.
  - IDLE → UPDATE on an accepted error event; the tap index idx is cleared to 0.
  - UPDATE: each cycle, coef[idx] ← sat16(coef[idx] + Δ), then idx increments. Δ = (e × x_hist[idx]) >>> (15 + MU_SHIFT).
    - The product is 32-bit signed.
    - The shift is arithmetic, so rounding is toward −∞.
    - The sum is formed in 17 bits and then saturated.
  - UPDATE → DONE after idx = 15 has been written.
  - DONE → IDLE unconditionally after one cycle; `upd_done` = 1 during DONE.
- History is frozen during UPDATE and DONE, so every tap uses the same snapshot.
- Simultaneous `x_valid` and accepted `err_valid` in IDLE:
  - the history shift is performed first;
  - the update uses the shifted history.
- `adapt_en` dropping during UPDATE has no effect; the current pass completes.
- During UPDATE the filter sees a mixed old/new coefficient set. This is accepted behaviour and is not masked.
- Reset at any point, including mid-UPDATE, returns the FSM to IDLE, history to 0, e to 0, and coefficients to their reset values. It aborts the partial pass.

## Timing
- Reset values of outputs: `ready` = 1, `upd_done` = 0, `coef[INIT_TAP]` = 0x7FFF, all other `coef` = 0x0000.
- Error event accepted in cycle T (IDLE):
  - UPDATE occupies cycles T+1 .. T+16, with idx = cycle − T − 1.
  - coef[k] shows its new value from cycle T+2+k.
  - DONE occurs in cycle T+17: `upd_done` = 1 and `ready` = 0.
  - IDLE resumes in cycle T+18 with `ready` = 1.
- `ready` = 0 from T+1 through T+17, so the minimum error-event spacing is 18 cycles.
- The history shift takes effect in the cycle after acceptance.
- All outputs are driven directly from registers; there is no combinational path from input to output.

## Test plan
- Reset check: assert rst_n low, then release.
  - Expected: coef[0] = 0x7FFF (INIT_TAP = 0), coef[1..15] = 0, `ready` = 1, `upd_done` = 0.
- Basic update:
  - Stimulus: 16 `x_valid` pulses with xn = 0x4000, then `err_valid` with dn = 0x2000, yn = 0.
  - Expected: e = 0x2000 and Δ = 0x0100. coef[1..15] = 0x0100; coef[0] saturates at 0x7FFF. `upd_done` pulses exactly 17 cycles after acceptance.
- Saturation and rounding:
  - Stimulus A: dn = 0x7FFF, yn = 0x8000. Expected: e clamps to 0x7FFF.
  - Stimulus B: x_hist[k] = 1, dn = 0, yn = 1 (e = −1). Expected: Δ = −1, so each coef[k] decrements by exactly 1.
  - Stimulus C: a tap at 0x8000 with negative Δ. Expected: it stays at 0x8000.
- Handshake:
  - `x_valid` pulsed during UPDATE: dropped, and the history is unchanged after DONE.
  - `err_valid` with `adapt_en` = 0: no update, `ready` stays 1.
  - `x_valid` and `err_valid` in the same cycle: the update uses the newly shifted sample at tap 0.
- Mid-update reset:
  - Stimulus: assert rst_n low at T+8.
  - Expected: all coefficients return to their reset values immediately, `ready` = 1 after release, and no `upd_done` pulse.
- Back-to-back:
  - Stimulus: two error events 18 cycles apart.
  - Expected: both are accepted, and the second pass uses the coefficients produced by the first.

Source files
------------

// File: rtl/lms_coef_update.sv
// LMS coefficient adaptation engine for a 16-tap equalizer FIR.
// Keeps its own input history and updates one tap per clock on each error event.
module lms_coef_update #(
    parameter int MU_SHIFT = 4,
    parameter int INIT_TAP = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               x_valid,
    input  logic signed [15:0] xn,
    input  logic               err_valid,
    input  logic signed [15:0] yn,
    input  logic signed [15:0] dn,
    input  logic               adapt_en,
    output logic               ready,
    output logic               upd_done,
    output logic signed [15:0] coef [16]
);

    // state  | meaning
    // IDLE   | accepting samples and error events
    // UPDATE | writing coef[idx_q], one tap per cycle
    // DONE   | one-cycle completion pulse, nothing accepted
    typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic signed [15:0] e_q, e_d;
    logic signed [15:0] x_hist_q [16];
    logic signed [15:0] coef_q [16];
    logic               ready_q, ready_d;
    logic               upd_done_q, upd_done_d;

    logic               x_acc, err_acc;
    logic signed [16:0] diff;
    logic signed [31:0] prod;
    logic signed [16:0] delta;
    logic signed [16:0] sum;
    logic signed [15:0] coef_new;

    assign x_acc   = x_valid && ready_q;
    assign err_acc = err_valid && adapt_en && ready_q;

    always_comb begin
        diff = {dn[15], dn} - {yn[15], yn};
        if (diff > 17'sd32767)
            e_d = 16'sh7FFF;
        else if (diff < -17'sd32768)
            e_d = 16'sh8000;
        else
            e_d = diff[15:0];
    end

    // Arithmetic shift floors toward -inf; the result always fits in 17 bits.
    always_comb begin
        prod  = $signed({{16{e_q[15]}}, e_q}) * $signed({{16{x_hist_q[idx_q][15]}}, x_hist_q[idx_q]});
        delta = 17'(prod >>> (15 + MU_SHIFT));
        sum   = {coef_q[idx_q][15], coef_q[idx_q]} + delta;
        if (sum > 17'sd32767)
            coef_new = 16'sh7FFF;
        else if (sum < -17'sd32768)
            coef_new = 16'sh8000;
        else
            coef_new = sum[15:0];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (err_acc) begin
                    state_d = UPDATE;
                    idx_d   = 4'd0;
                end
            end
            UPDATE: begin
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d    = (state_d == IDLE);
        upd_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 4'd0;
            e_q        <= 16'sh0000;
            ready_q    <= 1'b1;
            upd_done_q <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                x_hist_q[k] <= 16'sh0000;
                coef_q[k]   <= (k == INIT_TAP) ? 16'sh7FFF : 16'sh0000;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ready_q    <= ready_d;
            upd_done_q <= upd_done_d;
            if (err_acc)
                e_q <= e_d;
            // Shift happens before the update pass starts, so a same-cycle sample is used.
            if (x_acc) begin
                x_hist_q[0] <= xn;
                for (int k = 1; k < 16; k++)
                    x_hist_q[k] <= x_hist_q[k-1];
            end
            if (state_q == UPDATE)
                coef_q[idx_q] <= coef_new;
        end
    end

    assign ready    = ready_q;
    assign upd_done = upd_done_q;
    assign coef     = coef_q;

endmodule

// File: tb/tb_lms_coef_update.sv
// Randomized self-checking bench for lms_coef_update against a transaction-level model.
module tb_lms_coef_update;

    localparam int MU = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               x_valid = 1'b0;
    logic signed [15:0] xn = '0;
    logic               err_valid = 1'b0;
    logic signed [15:0] yn = '0;
    logic signed [15:0] dn = '0;
    logic               adapt_en = 1'b0;
    logic               ready;
    logic               upd_done;
    logic signed [15:0] coef [16];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mh [16];
    int mc [16];
    int last_acc = 0;

    lms_coef_update #(.MU_SHIFT(MU), .INIT_TAP(0)) dut (
        .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .xn(xn),
        .err_valid(err_valid), .yn(yn), .dn(dn), .adapt_en(adapt_en),
        .ready(ready), .upd_done(upd_done), .coef(coef)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic int fdiv(input longint p, input int sh);
        longint d, q;
        d = longint'(1) << sh;
        q = p / d;
        if ((p % d) != 0 && p < 0) q = q - 1;
        return int'(q);
    endfunction

    function automatic void m_reset();
        for (int k = 0; k < 16; k++) begin
            mh[k] = 0;
            mc[k] = (k == 0) ? 32767 : 0;
        end
    endfunction

    function automatic void m_push(input int v);
        for (int k = 15; k > 0; k--) mh[k] = mh[k-1];
        mh[0] = v;
    endfunction

    function automatic void m_update(input int e);
        for (int k = 0; k < 16; k++)
            mc[k] = sat16(longint'(mc[k]) + fdiv(longint'(e) * mh[k], 15 + MU));
    endfunction

    task automatic cmp_all(input string tag);
        for (int k = 0; k < 16; k++)
            chk($sformatf("%s_c%0d", tag, k), int'(coef[k]), mc[k]);
    endtask

    task automatic push_x(input int v);
        @(negedge clk);
        x_valid = 1'b1;
        xn = v[15:0];
        @(negedge clk);
        x_valid = 1'b0;
        m_push(v);
    endtask

    task automatic do_err(input string tag, input int dv, input int yv,
                          input bit with_x, input int xv, input bit x_during);
        int oldc [16];
        int got;
        @(negedge clk);
        chk({tag, "_pre_ready"}, int'(ready), 1);
        dn = dv[15:0];
        yn = yv[15:0];
        err_valid = 1'b1;
        adapt_en = 1'b1;
        if (with_x) begin
            x_valid = 1'b1;
            xn = xv[15:0];
            m_push(xv);
        end
        oldc = mc;
        m_update(sat16(longint'(dv) - yv));
        last_acc = cyc;
        @(negedge clk);
        err_valid = 1'b0;
        x_valid = 1'b0;
        adapt_en = 1'b0;
        chk({tag, "_busy_ready"}, int'(ready), 0);
        got = 0;
        for (int n = 1; n <= 30; n++) begin
            if (n > 1) @(negedge clk);
            if (x_during && n == 5) begin
                x_valid = 1'b1;
                xn = 16'($urandom);
            end
            if (n == 6) x_valid = 1'b0;
            if (n == 9) begin
                chk({tag, "_mid_new7"}, int'(coef[7]), mc[7]);
                chk({tag, "_mid_old8"}, int'(coef[8]), oldc[8]);
            end
            if (upd_done) begin
                got = n;
                break;
            end
        end
        chk({tag, "_done_lat"}, got, 17);
        chk({tag, "_done_ready"}, int'(ready), 0);
        cmp_all(tag);
    endtask

    task automatic no_adapt();
        @(negedge clk);
        dn = 16'($urandom);
        yn = 16'($urandom);
        err_valid = 1'b1;
        adapt_en = 1'b0;
        @(negedge clk);
        err_valid = 1'b0;
        chk("noadapt_ready", int'(ready), 1);
        repeat (3) @(negedge clk);
        chk("noadapt_done", int'(upd_done), 0);
        chk("noadapt_ready2", int'(ready), 1);
        cmp_all("noadapt");
    endtask

    initial begin
        int t1;
        int passes;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(ready), 1);
        chk("rst_done", int'(upd_done), 0);
        cmp_all("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rel_ready", int'(ready), 1);

        // basic update
        for (int i = 0; i < 16; i++) push_x(16'h4000);
        do_err("basic", 16'h2000, 0, 1'b0, 0, 1'b0);
        chk("basic_c1_const", int'(coef[1]), 16'h0100);
        chk("basic_c0_const", int'(coef[0]), 32767);

        // error clamps at +32767
        do_err("satA", 32767, -32768, 1'b0, 0, 1'b0);

        // e = -1 with unit history: each tap drops by exactly one
        for (int i = 0; i < 16; i++) push_x(1);
        t1 = int'(coef[5]);
        do_err("rndB", 0, 1, 1'b0, 0, 1'b0);
        chk("rndB_dec", int'(coef[5]), t1 - 1);

        // x_valid during the pass is dropped; next pass proves history unchanged
        push_x(int'($urandom_range(0, 65535)) - 32768);
        do_err("xdrop", 4000, -3000, 1'b0, 0, 1'b1);
        do_err("xdrop2", -12000, 9000, 1'b0, 0, 1'b0);

        // same-cycle sample and error event
        do_err("simul", 20000, -5000, 1'b1, 31000, 1'b0);

        for (int it = 0; it < 8; it++) begin
            int np;
            np = int'($urandom_range(0, 4));
            for (int i = 0; i < np; i++) push_x(int'($urandom_range(0, 65535)) - 32768);
            if ($urandom_range(0, 3) == 0)
                no_adapt();
            else
                do_err($sformatf("rand%0d", it), int'($urandom_range(0, 65535)) - 32768,
                       int'($urandom_range(0, 65535)) - 32768, $urandom_range(0, 1) == 1,
                       int'($urandom_range(0, 65535)) - 32768, 1'b0);
        end

        // drive taps down to the negative rail and hold there
        for (int i = 0; i < 16; i++) push_x(32767);
        passes = 0;
        while (mc[1] != -32768 && passes < 40) begin
            do_err("satC", -32768, 32767, 1'b0, 0, 1'b0);
            passes++;
        end
        do_err("satC_hold", -32768, 32767, 1'b0, 0, 1'b0);
        chk("satC_min", int'(coef[1]), -32768);

        // reset in the middle of a pass
        @(negedge clk);
        dn = 16'h3000;
        yn = 16'h0000;
        err_valid = 1'b1;
        adapt_en = 1'b1;
        @(negedge clk);
        err_valid = 1'b0;
        adapt_en = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        m_reset();
        #1;
        cmp_all("midrst");
        chk("midrst_done", int'(upd_done), 0);
        repeat (3) @(negedge clk);
        chk("midrst_done2", int'(upd_done), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", int'(ready), 1);
        repeat (20) @(negedge clk);
        chk("midrst_nodone", int'(upd_done), 0);
        cmp_all("midrst_after");

        // back-to-back events 18 cycles apart
        for (int i = 0; i < 16; i++) push_x(int'($urandom_range(0, 65535)) - 32768);
        do_err("b2b1", 25000, -6000, 1'b0, 0, 1'b0);
        t1 = last_acc;
        do_err("b2b2", -9000, 14000, 1'b0, 0, 1'b0);
        chk("b2b_spacing", last_acc - t1, 18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
